// File: rtl/rvc_pkg.sv
// Shared RV32C definitions: base opcodes, FIFO entry type and the halfword
// classification helper used by the aligner and the expander.
package rvc_pkg;

  localparam logic [6:0] OPCODE_I      = 7'h13;
  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_R      = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

  typedef struct packed {
    logic [15:0] hw;
    logic        err;
  } fifo_entry_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C 16-to-32-bit expander with illegal-encoding flag.
module rvc_expander
  import rvc_pkg::*;
(
  input  logic [15:0] instr_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p, rs2p;
  logic [11:0] imm6;

  assign c    = instr_i;
  assign rd   = c[11:7];
  assign rs2  = c[6:2];
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign rs2p = {2'b01, c[4:2]};
  assign imm6 = {{7{c[12]}}, c[6:2]};

  always_comb begin
    instr_o   = {16'h0000, c};
    illegal_o = 1'b0;
    unique case (c[1:0])
      2'b00: begin
        unique case (c[15:13])
          3'b000: begin
            instr_o   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OPCODE_I};
            illegal_o = (c[12:5] == 8'h00);
          end
          3'b010: instr_o = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OPCODE_LOAD};
          3'b110: instr_o = {5'b0, c[5], c[12], rs2p, rs1p, 3'b010, c[11:10], c[6], 2'b00, OPCODE_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      2'b01: begin
        unique case (c[15:13])
          3'b000: instr_o = {imm6, rd, 3'b000, rd, OPCODE_I};
          3'b001, 3'b101:
            instr_o = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                       c[15] ? 5'd0 : 5'd1, OPCODE_JAL};
          3'b010: instr_o = {imm6, 5'd0, 3'b000, rd, OPCODE_I};
          3'b011: begin
            if (rd == 5'd2)
              instr_o = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, OPCODE_I};
            else
              instr_o = {{15{c[12]}}, c[6:2], rd, OPCODE_LUI};
            illegal_o = ({c[12], c[6:2]} == 6'b0);
          end
          3'b100: begin
            unique case (c[11:10])
              2'b00: begin
                instr_o   = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPCODE_I};
                illegal_o = c[12];
              end
              2'b01: begin
                instr_o   = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPCODE_I};
                illegal_o = c[12];
              end
              2'b10: instr_o = {imm6, rs1p, 3'b111, rs1p, OPCODE_I};
              default: begin
                unique case (c[6:5])
                  2'b00:   instr_o = {7'b0100000, rs2p, rs1p, 3'b000, rs1p, OPCODE_R};
                  2'b01:   instr_o = {7'b0000000, rs2p, rs1p, 3'b100, rs1p, OPCODE_R};
                  2'b10:   instr_o = {7'b0000000, rs2p, rs1p, 3'b110, rs1p, OPCODE_R};
                  default: instr_o = {7'b0000000, rs2p, rs1p, 3'b111, rs1p, OPCODE_R};
                endcase
                illegal_o = c[12];
              end
            endcase
          end
          default:
            instr_o = {{4{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 2'b00, c[13], c[11:10], c[4:3], c[12],
                       OPCODE_BRANCH};
        endcase
      end
      2'b10: begin
        unique case (c[15:13])
          3'b000: begin
            instr_o   = {7'b0000000, c[6:2], rd, 3'b001, rd, OPCODE_I};
            illegal_o = c[12];
          end
          3'b010: begin
            instr_o   = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, OPCODE_LOAD};
            illegal_o = (rd == 5'd0);
          end
          3'b100: begin
            if (!c[12]) begin
              if (rs2 == 5'd0) begin
                instr_o   = {12'h000, rd, 3'b000, 5'd0, OPCODE_JALR};
                illegal_o = (rd == 5'd0);
              end else begin
                instr_o = {7'b0000000, rs2, 5'd0, 3'b000, rd, OPCODE_R};
              end
            end else if (rs2 == 5'd0) begin
              instr_o = (rd == 5'd0) ? {12'h001, 13'h0000, OPCODE_SYSTEM}
                                     : {12'h000, rd, 3'b000, 5'd1, OPCODE_JALR};
            end else begin
              instr_o = {7'b0000000, rs2, rd, 3'b000, rd, OPCODE_R};
            end
          end
          3'b110: instr_o = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, OPCODE_STORE};
          default: illegal_o = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword FIFO realigning mixed 16/32-bit fetch streams into one expanded
// instruction per handshake. Define RVC_ALIGNER_OUT_REG_EN for a registered output stage.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_raw_o,
  output logic [31:0] out_pc_o,
  output logic        out_compressed_o,
  output logic        out_illegal_o,
  output logic        out_fetch_err_o
);

  localparam int unsigned NENT = 2 * DEPTH;
  localparam int unsigned PW   = $clog2(NENT);
  localparam int unsigned CW   = $clog2(NENT + 1);

  fifo_entry_t   fifo_q [NENT];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_p1, wr_ptr_p1;
  logic [CW-1:0] count_q;
  logic [31:0]   pc_q;
  logic          drop_first_q;

  fifo_entry_t head, second;
  logic        head_c, head_valid, head_err, head_ill, exp_illegal, push, pop;
  logic [1:0]  push_n, pop_n;
  logic [31:0] head_raw, head_instr, exp_instr;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
    int unsigned s;
    s = 32'(p) + 32'(n);
    if (s >= NENT) s = s - NENT;
    return PW'(s);
  endfunction

  assign rd_ptr_p1 = ptr_add(rd_ptr_q, 2'd1);
  assign wr_ptr_p1 = ptr_add(wr_ptr_q, 2'd1);
  assign head      = fifo_q[rd_ptr_q];
  assign second    = fifo_q[rd_ptr_p1];

  rvc_expander u_expander (
    .instr_i   (head.hw),
    .instr_o   (exp_instr),
    .illegal_o (exp_illegal)
  );

  // An errored head goes out alone so the error is reported at its own PC.
  always_comb begin
    head_c     = is_compressed(head.hw);
    head_valid = (count_q >= (head_c ? CW'(1) : CW'(2))) || ((count_q != '0) && head.err);
    head_err   = head.err || (!head_c && second.err);
    head_raw   = head_c ? {16'h0000, head.hw} : {second.hw, head.hw};
    head_instr = head_c ? exp_instr : head_raw;
    head_ill   = head_c && exp_illegal && !head_err;
    pop_n      = (head_c || head.err) ? 2'd1 : 2'd2;
    push_n     = drop_first_q ? 2'd1 : 2'd2;
  end

  assign fetch_ready_o = (count_q <= CW'(NENT - 2));
  assign push          = fetch_valid_i && fetch_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NENT; i++) fifo_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pc_q         <= BOOT_ADDR & ~32'h1;
      drop_first_q <= BOOT_ADDR[1];
    end else if (flush_i) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pc_q         <= flush_pc_i & ~32'h1;
      drop_first_q <= flush_pc_i[1];
    end else begin
      if (push) begin
        if (drop_first_q) begin
          fifo_q[wr_ptr_q] <= '{hw: fetch_rdata_i[31:16], err: fetch_err_i};
        end else begin
          fifo_q[wr_ptr_q]  <= '{hw: fetch_rdata_i[15:0], err: fetch_err_i};
          fifo_q[wr_ptr_p1] <= '{hw: fetch_rdata_i[31:16], err: fetch_err_i};
        end
        wr_ptr_q     <= ptr_add(wr_ptr_q, push_n);
        drop_first_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= ptr_add(rd_ptr_q, pop_n);
        pc_q     <= pc_q + (head_c ? 32'd2 : 32'd4);
      end
      count_q <= count_q + (push ? CW'(push_n) : '0) - (pop ? CW'(pop_n) : '0);
    end
  end

`ifdef RVC_ALIGNER_OUT_REG_EN
  logic        o_valid_q, o_comp_q, o_ill_q, o_err_q, stage_load;
  logic [31:0] o_instr_q, o_raw_q, o_pc_q;

  assign stage_load = !o_valid_q || out_ready_i;
  assign pop        = head_valid && stage_load;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      o_valid_q <= 1'b0;
      o_instr_q <= '0;
      o_raw_q   <= '0;
      o_pc_q    <= '0;
      o_comp_q  <= 1'b0;
      o_ill_q   <= 1'b0;
      o_err_q   <= 1'b0;
    end else if (flush_i) begin
      o_valid_q <= 1'b0;
    end else if (stage_load) begin
      o_valid_q <= head_valid;
      o_instr_q <= head_valid ? head_instr : '0;
      o_raw_q   <= head_valid ? head_raw : '0;
      o_pc_q    <= head_valid ? pc_q : '0;
      o_comp_q  <= head_valid && head_c;
      o_ill_q   <= head_valid && head_ill;
      o_err_q   <= head_valid && head_err;
    end
  end

  assign out_valid_o      = o_valid_q;
  assign out_instr_o      = o_instr_q;
  assign out_raw_o        = o_raw_q;
  assign out_pc_o         = o_pc_q;
  assign out_compressed_o = o_comp_q;
  assign out_illegal_o    = o_ill_q;
  assign out_fetch_err_o  = o_err_q;
`else
  assign pop              = head_valid && out_ready_i;
  assign out_valid_o      = head_valid;
  assign out_instr_o      = head_valid ? head_instr : '0;
  assign out_raw_o        = head_valid ? head_raw : '0;
  assign out_pc_o         = head_valid ? pc_q : '0;
  assign out_compressed_o = head_valid && head_c;
  assign out_illegal_o    = head_valid && head_ill;
  assign out_fetch_err_o  = head_valid && head_err;
`endif

endmodule
